// File: rtl/portgroup_rx_sched.sv
// Ping-pong receive scheduler: stores stream words alternately into rx_data0/rx_data1 with per-slot full flags.
// Optional drop counter for words arriving while disabled: define PORTGROUP_RX_SCHED_DROPCNT_EN.
module portgroup_rx_sched #(
  parameter int unsigned width_p = 8
) (
  input  logic               main_clk_i,
  input  logic               main_rst_i,
  input  logic               ena_i,
  input  logic               rx_valid_i,
  output logic               rx_ready_o,
  input  logic [width_p-1:0] rx_data_i,
  input  logic [1:0]         rd_ack_i,
  output logic [width_p-1:0] data0_o,
  output logic [width_p-1:0] data1_o,
  output logic [1:0]         full_o,
  output logic               irq_o,
  output logic [7:0]         drop_cnt_o
);

  typedef enum logic [1:0] {DIS, SEL0, SEL1} state_e;

  state_e     state_q, state_d;
  logic       accept;
  logic       store;
  logic [1:0] set_mask;

  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) state_q <= DIS;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIS:     if (ena_i) state_d = SEL0;
      SEL0:    if (!ena_i) state_d = DIS; else if (accept) state_d = SEL1;
      SEL1:    if (!ena_i) state_d = DIS; else if (accept) state_d = SEL0;
      default: state_d = DIS;
    endcase
  end

  // Ready is derived from flops only, so no input-to-output combinational path exists.
  always_comb begin
    rx_ready_o = 1'b1;
    unique case (state_q)
      SEL0:    rx_ready_o = ~full_o[0];
      SEL1:    rx_ready_o = ~full_o[1];
      default: rx_ready_o = 1'b1;
    endcase
  end

  assign accept   = rx_valid_i & rx_ready_o;
  assign store    = accept & (state_q != DIS);
  assign set_mask = {store & (state_q == SEL1), store & (state_q == SEL0)};

  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      data0_o <= '0;
      data1_o <= '0;
      full_o  <= '0;
      irq_o   <= 1'b0;
    end else begin
      if (set_mask[0]) data0_o <= rx_data_i;
      if (set_mask[1]) data1_o <= rx_data_i;
      // A word stored as ena falls still lands in its data register, but the flags clear on entering DIS.
      if (state_q == DIS || !ena_i) full_o <= '0;
      else                          full_o <= (full_o & ~rd_ack_i) | set_mask;
      irq_o <= store;
    end
  end

`ifdef PORTGROUP_RX_SCHED_DROPCNT_EN
  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i)                                        drop_cnt_o <= '0;
    else if (accept && state_q == DIS && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 8'd1;
  end
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_portgroup_rx_sched.sv
// Bench for portgroup_rx_sched: directed test-plan steps plus random traffic against a slot-level model.
module tb_portgroup_rx_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] rx_data = '0;
  logic [1:0] rd_ack = '0;
  logic [7:0] data0, data1;
  logic [1:0] full;
  logic       irq;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_en;
  int         m_next;
  logic [7:0] m_data [2];
  bit         m_full [2];
  int         m_drop;
  bit         m_irq;

  portgroup_rx_sched #(.width_p(8)) dut (
    .main_clk_i(clk), .main_rst_i(rst), .ena_i(ena),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data),
    .rd_ack_i(rd_ack), .data0_o(data0), .data1_o(data1),
    .full_o(full), .irq_o(irq), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return !m_en || !m_full[m_next];
  endfunction

  function automatic logic [7:0] drop_exp();
`ifdef PORTGROUP_RX_SCHED_DROPCNT_EN
    return 8'(m_drop);
`else
    return 8'd0;
`endif
  endfunction

  task automatic model_reset();
    m_en = 0; m_next = 0; m_data[0] = '0; m_data[1] = '0;
    m_full[0] = 0; m_full[1] = 0; m_drop = 0; m_irq = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":data0"}, 32'(data0), 32'(m_data[0]));
    chk({tag, ":data1"}, 32'(data1), 32'(m_data[1]));
    chk({tag, ":full"},  32'(full),  32'({m_full[1], m_full[0]}));
    chk({tag, ":irq"},   32'(irq),   32'(m_irq));
    chk({tag, ":drop"},  32'(drop_cnt), 32'(drop_exp()));
    chk({tag, ":ready"}, 32'(rx_ready), 32'(m_ready()));
  endtask

  // Called just after a rising edge: drive inputs, predict the next edge, then check after it.
  task automatic step(input string tag, input bit v, input logic [7:0] d,
                      input logic [1:0] ack, input bit en);
    bit acc;
    rx_valid = v; rx_data = d; rd_ack = ack; ena = en;
    #1;
    chk({tag, ":ready_pre"}, 32'(rx_ready), 32'(m_ready()));
    acc   = v && m_ready();
    m_irq = acc && m_en;
    if (!m_en) begin
      if (acc && m_drop < 255) m_drop++;
      if (en) begin m_en = 1; m_next = 0; end
    end else begin
      for (int n = 0; n < 2; n++) if (ack[n]) m_full[n] = 0;
      if (acc) begin
        m_data[m_next] = d;
        m_full[m_next] = 1;
        m_next ^= 1;
      end
      if (!en) begin m_en = 0; m_full[0] = 0; m_full[1] = 0; end
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // Words while disabled are accepted and dropped
    step("dis11", 1, 8'h11, 2'b00, 0);
    step("dis22", 1, 8'h22, 2'b00, 0);
    step("dis33", 1, 8'h33, 2'b00, 0);
    chk("drop3", 32'(drop_cnt), 32'(drop_exp()));

    // Enable, fill both slots, third word held
    step("ena",   0, 8'h00, 2'b00, 1);
    step("wA1",   1, 8'hA1, 2'b00, 1);
    step("wA2",   1, 8'hA2, 2'b00, 1);
    chk("full11", 32'(full), 32'h3);
    step("holdA3", 1, 8'hA3, 2'b00, 1);
    chk("held_ready", 32'(rx_ready), 32'h0);
    step("ack0",  1, 8'hA3, 2'b01, 1);
    chk("ready_after_ack", 32'(rx_ready), 32'h1);
    step("wA3",   1, 8'hA3, 2'b00, 1);
    chk("A3_slot0", 32'(data0), 32'hA3);

    // Write slot 1 together with ack of slot 0
    step("ack1",  0, 8'h00, 2'b10, 1);
    step("wB1_ack0", 1, 8'hB1, 2'b01, 1);
    chk("full10", 32'(full), 32'h2);

    // Disable with both slots full, re-enable restarts at slot 0
    step("ack1b", 0, 8'h00, 2'b10, 1);
    step("wB2",   1, 8'hB2, 2'b00, 1);
    step("wB3",   1, 8'hB3, 2'b00, 1);
    chk("full11b", 32'(full), 32'h3);
    step("disable", 0, 8'h00, 2'b00, 0);
    chk("full_cleared", 32'(full), 32'h0);
    step("reena", 0, 8'h00, 2'b00, 1);
    step("wC1",   1, 8'hC1, 2'b00, 1);
    chk("C1_slot0", 32'(data0), 32'hC1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", bit'($urandom_range(0, 3) != 0), 8'($urandom),
           2'($urandom_range(0, 3)), bit'($urandom_range(0, 15) != 0));
    end

    // Saturation of the drop counter
    for (int i = 0; i < 300; i++) step("sat", 1, 8'($urandom), 2'b00, 0);
`ifdef PORTGROUP_RX_SCHED_DROPCNT_EN
    chk("drop_sat", 32'(drop_cnt), 32'd255);
`else
    chk("drop_tied", 32'(drop_cnt), 32'd0);
`endif

    // Asynchronous reset mid-operation
    step("pre_rst_ena", 0, 8'h00, 2'b00, 1);
    step("pre_rst_w",   1, 8'h5A, 2'b00, 1);
    rx_valid = 1'b1; rx_data = 8'h77;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_full",  32'(full),     32'h0);
    chk("async_data0", 32'(data0),    32'h0);
    chk("async_drop",  32'(drop_cnt), 32'h0);
    chk("async_ready", 32'(rx_ready), 32'h1);
    chk("async_irq",   32'(irq),      32'h0);
    rx_valid = 1'b0; ena = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst", 0, 8'h00, 2'b00, 1);
    step("post_rst_w", 1, 8'h3C, 2'b00, 1);
    chk("post_rst_slot0", 32'(data0), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/portgroup_rx_sched.md
# portgroup_rx_sched

Core-side receive scheduler for the `portgroup_rx` register group. It takes a valid/ready stream of `width_p`-bit words and ping-pongs them into the two bus-readable receive registers, `rx_data0` and `rx_data1`. It tracks a full flag per slot and applies back-pressure when the next slot is still unread. The block is gated by the register-file `ctrl_ena` read value and sits between the core receive datapath and the regf core ports.

## Interface
Parameters:
- `width_p`, default 8: receive word width; same value as the regf instance.

Ports:
- `main_clk_i`  in  1  main clock
- `main_rst_i`  in  1  reset; asynchronous, active-high
- `ena_i`  in  1  from `regf_ctrl_ena_rval_i`; block enable
- `rx_valid_i`  in  1  stream word valid
- `rx_ready_o`  out  1  stream word accepted when `rx_valid_i & rx_ready_o`
- `rx_data_i`  in  `width_p`  stream word
- `rd_ack_i`  in  2  one-cycle pulse per slot: bus has read slot n (bit0 = data0, bit1 = data1)
- `data0_o`  out  `width_p`  to `regf_rx_data0_rbus_o`
- `data1_o`  out  `width_p`  to `regf_rx_data1_rbus_o`
- `full_o`  out  2  slot n holds unread data
- `irq_o`  out  1  one-cycle pulse: a slot was filled
- `drop_cnt_o`  out  8  saturating count of words discarded while disabled

## Operation
State machine with states DIS, SEL0 and SEL1 (next write slot 0 or 1). Reset state is DIS.

Transitions:
- DIS -> SEL0 when `ena_i`=1.
- SEL0 -> SEL1 on an accepted word.
- SEL1 -> SEL0 on an accepted word.
- SEL0/SEL1 -> DIS when `ena_i`=0.
- A handshake in the same cycle that `ena_i` falls is still stored; the state then goes to DIS.

`rx_ready_o` depends only on flops; there is no combinational path from any input:
- 1 in DIS.
- In SELn, equals `~full_o[n]`.

Accepted word in SELn:
- `dataN_o` <= `rx_data_i`.
- `full_o[n]` <= 1.
- `irq_o` <= 1 for one cycle.

Accepted word in DIS: discarded, and `drop_cnt_o` increments. It saturates at 255 and does not wrap.

`rd_ack_i[n]`:
- Clears `full_o[n]` next cycle.
- An ack of an empty slot is ignored.
- `dataN_o` keeps its value; the slot is not cleared.

Simultaneous events:
- Write to slot n and ack of slot n in the same cycle: not possible, since ready was 0.
- Write to slot n and ack of slot m≠n: both take effect.
- Acks of both slots together: both flags cleared.

Entering DIS:
- `full_o` cleared to 0.
- Data registers retained.
- The next enable starts at slot 0.

`drop_cnt_o` clears only on reset.

Reset values: `data0_o`=0, `data1_o`=0, `full_o`=0, `irq_o`=0, `drop_cnt_o`=0. `rx_ready_o`=1 because the state is DIS.

Reset mid-operation: every flop returns to its reset value immediately (asynchronous). Any in-flight handshake is lost.

## Timing
- Capture latency: word accepted at edge k. `data_o`, `full_o` and `irq_o` update at edge k (visible in cycle k+1).
- `ena_i` 0->1 at cycle k: state SEL0 from k+1. The first word can be stored in slot 0 from cycle k+1.
- `rd_ack_i[n]` at cycle k: `full_o[n]`=0 and `rx_ready_o` can rise in cycle k+1. A word can be accepted in cycle k+1.
- Sustained throughput: 1 word/cycle while both slots drain with acks at the same rate.
- `irq_o` is a single-cycle pulse per stored word; back-to-back stores give a continuous high.

## Configuration
`PORTGROUP_RX_SCHED_DROPCNT_EN`:
- Defined: drop counter present as described above.
- Not defined: no counter flops; `drop_cnt_o` is tied to 0. Words in DIS are still accepted and discarded.

## Test plan
- Reset released with `ena_i`=0, then 3 words 0x11/0x22/0x33 sent -> all accepted; `drop_cnt_o`=3; `full_o`=0; `data0_o`=`data1_o`=0.
- `ena_i`=1, then words 0xA1, 0xA2 with no acks -> `data0_o`=0xA1, `data1_o`=0xA2, `full_o`=2'b11, two `irq_o` pulses; word 0xA3 held (`rx_ready_o`=0).
- From the previous state, `rd_ack_i`=2'b01 -> one cycle later `rx_ready_o`=1; 0xA3 lands in slot 0; `full_o`=2'b11.
- Word stored to slot 1 in the same cycle as `rd_ack_i`=2'b01 -> both take effect: `full_o`=2'b10 next cycle.
- Disable with `full_o`=2'b11, then re-enable -> `full_o`=0, data retained, next word goes to `data0_o`.
- 300 words with `ena_i`=0 -> `drop_cnt_o` saturates at 255. With the macro undefined -> `drop_cnt_o` stays 0.
